// File: rtl/delay_line_fx.sv
// delay_line_fx
// Delay/echo effect: each accepted sample is summed with a gain-scaled tap
// read from a circular sample buffer, delay_time samples in the past. The
// buffer is zeroed after reset, one address per cycle, before the first
// sample is accepted. A new sample can be accepted at most every 4 cycles,
// and its result appears 2 cycles after acceptance.
//
// Optional feature: DELAY_FEEDBACK_EN
//   defined   : the buffer stores sat(in + tap*feedback_gain), so the echo
//               repeats and decays.
//   undefined : the buffer stores the dry input. feedback_gain is ignored,
//               so each input produces exactly one echo.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset (restarts the buffer clear)
//   bypass        1 = output equals input, latched at acceptance
//   delay_time    delay in samples, 0 disables the wet path
//   mix_gain      wet gain, unsigned Q1.(GAIN_W-1)
//   feedback_gain regeneration gain, unsigned Q1.(GAIN_W-1)
//   in_valid      input sample valid
//   in_ready      block can accept a sample this cycle
//   in_sample     signed input sample
//   out_valid     one-cycle pulse, out_sample is new
//   out_sample    signed output sample, held until the next pulse
module delay_line_fx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned GAIN_W = 8,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bypass,
    input  logic [AW-1:0]     delay_time,
    input  logic [GAIN_W-1:0] mix_gain,
    input  logic [GAIN_W-1:0] feedback_gain,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sample
);

    // Product width: signed sample times zero-extended gain.
    localparam int unsigned PW = DATA_W + GAIN_W + 1;
    // Sum width: dry plus wet with one guard bit.
    localparam int unsigned SW = PW + 1;

    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        CALC,
        OUT
    } state_t;

    state_t                   state;
    logic [AW-1:0]            wr_ptr;

    // Controls and sample latched at acceptance.
    logic signed [DATA_W-1:0] in_q;
    logic                     byp_q;
    logic [AW-1:0]            dly_q;
    logic [GAIN_W-1:0]        mix_q;
`ifdef DELAY_FEEDBACK_EN
    logic [GAIN_W-1:0]        fb_q;
`else
    logic                     unused_fb;
`endif

    // Sample buffer with synchronous read.
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] rd_data;

    logic                     mem_we_c;
    logic [AW-1:0]            rd_addr_c;
    logic signed [DATA_W-1:0] mem_wdata_c;
    logic signed [DATA_W-1:0] tap_c;
    logic signed [DATA_W-1:0] out_c;
    logic signed [DATA_W-1:0] wr_data_c;

    // (x * g) >>> (GAIN_W-1) with g taken as an unsigned Q1.(GAIN_W-1) gain.
    function automatic logic signed [PW-1:0] scale(
        input logic signed [DATA_W-1:0] x,
        input logic [GAIN_W-1:0]        g
    );
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ge;
        logic signed [PW-1:0] p;
        xe = PW'(x);
        ge = $signed(PW'(g));
        p  = xe * ge;
        return p >>> (GAIN_W - 1);
    endfunction

    // Full-width add, then clamp to the signed sample range.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [PW-1:0]     b
    );
        logic signed [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end else if (s < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end
        return DATA_W'(s);
    endfunction

    // Tap address trails the write pointer; AW-bit arithmetic wraps mod DEPTH.
    assign rd_addr_c = wr_ptr - dly_q;

    // CALC datapath: wet mix for the output, and the value to record.
    always_comb begin
        tap_c = (dly_q == '0) ? '0 : rd_data;
        out_c = byp_q ? in_q : sat_add(in_q, scale(tap_c, mix_q));
`ifdef DELAY_FEEDBACK_EN
        wr_data_c = byp_q ? in_q : sat_add(in_q, scale(tap_c, fb_q));
`else
        wr_data_c = in_q;
`endif
    end

`ifndef DELAY_FEEDBACK_EN
    assign unused_fb = ^feedback_gain;
`endif

    // Reset blocks the write so an in-flight sample is dropped.
    assign mem_we_c    = !reset && ((state == CLEAR) || (state == CALC));
    assign mem_wdata_c = (state == CALC) ? wr_data_c : '0;

    // Buffer port: write at wr_ptr, registered read in READ.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_ptr] <= mem_wdata_c;
        end
        if (state == READ) begin
            rd_data <= mem[rd_addr_c];
        end
    end

    // Control FSM with registered handshake and output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            wr_ptr     <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            in_q       <= '0;
            byp_q      <= 1'b0;
            dly_q      <= '0;
            mix_q      <= '0;
`ifdef DELAY_FEEDBACK_EN
            fb_q       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                // wr_ptr doubles as the clear address and wraps back to 0.
                CLEAR: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (wr_ptr == AW'(DEPTH - 1)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        in_q     <= $signed(in_sample);
                        byp_q    <= bypass;
                        dly_q    <= delay_time;
                        mix_q    <= mix_gain;
`ifdef DELAY_FEEDBACK_EN
                        fb_q     <= feedback_gain;
`endif
                        in_ready <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= CALC;
                end
                CALC: begin
                    out_sample <= out_c;
                    out_valid  <= 1'b1;
                    wr_ptr     <= wr_ptr + AW'(1);
                    state      <= OUT;
                end
                OUT: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    wr_ptr   <= '0;
                    in_ready <= 1'b0;
                    state    <= CLEAR;
                end
            endcase
        end
    end

endmodule
